// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - 8N1 UART receiver, OVERSAMPLE clocks per bit, centre sampling
// Optional: SERIAL_RX_MAJORITY_EN selects 2-of-3 majority voting at each sample point.
module serial_rx #(
    parameter int OVERSAMPLE = 16,
    localparam int CW = $clog2(OVERSAMPLE)
) (
    input  logic       clk1843,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rbyte,
    output logic       rbyte_rdy,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CW-1:0] H_M1  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] OS_M1 = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [7:0]    rbyte_nxt;
    logic          rdy_nxt;
    logic          ferr_nxt;
    logic          rx_meta, rx_s;
    logic          sample;

    always_ff @(posedge clk1843) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef SERIAL_RX_MAJORITY_EN
    // Two earlier taps are captured just before the nominal point; the vote
    // completes with the live rx_s so the decision cycle is unchanged.
    logic [CW-1:0] samp_pt;
    logic          maj_a, maj_b;

    always_comb begin
        samp_pt = (state == START) ? H_M1 : OS_M1;
    end

    always_ff @(posedge clk1843) begin
        if (!rst_n) begin
            maj_a <= 1'b1;
            maj_b <= 1'b1;
        end else begin
            if (cnt == samp_pt - CW'(2)) maj_a <= rx_s;
            if (cnt == samp_pt - CW'(1)) maj_b <= rx_s;
        end
    end

    assign sample = (maj_a & maj_b) | (maj_a & rx_s) | (maj_b & rx_s);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clk1843) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rbyte     <= 8'h00;
            rbyte_rdy <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_nxt;
            shift     <= shift_nxt;
            rbyte     <= rbyte_nxt;
            rbyte_rdy <= rdy_nxt;
            frame_err <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        rbyte_nxt = rbyte;
        rdy_nxt   = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (cnt == H_M1) begin
                    cnt_nxt = '0;
                    if (!sample) begin
                        state_nxt = DATA;
                        bit_nxt   = 3'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == OS_M1) begin
                    cnt_nxt   = '0;
                    shift_nxt = {sample, shift[7:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                // Leaving at the stop-bit centre leaves half a bit to catch the next start edge.
                if (cnt == OS_M1) begin
                    cnt_nxt = '0;
                    if (sample) begin
                        rbyte_nxt = shift;
                        rdy_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - directed self-checking bench for serial_rx (OVERSAMPLE=16)
module tb_serial_rx;

    logic       clk1843 = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic [7:0] rbyte;
    logic       rbyte_rdy;
    logic       frame_err;
    logic       busy;

    int unsigned cyc = 0;
    int unsigned frame_t0 = 0;
    int unsigned last_rdy = 0;
    int unsigned prev_rdy = 0;
    int          rdy_cnt = 0;
    int          ferr_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  byte_q[$];

    serial_rx #(.OVERSAMPLE(16)) dut (
        .clk1843  (clk1843),
        .rst_n    (rst_n),
        .rx       (rx),
        .rbyte    (rbyte),
        .rbyte_rdy(rbyte_rdy),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk1843 = ~clk1843;

    always @(posedge clk1843) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk1843) begin
        if (rbyte_rdy) begin
            rdy_cnt++;
            prev_rdy = last_rdy;
            last_rdy = cyc;
            byte_q.push_back(rbyte);
        end
        if (frame_err) ferr_cnt++;
        if (rbyte_rdy || frame_err) check("strobe_excl", {31'd0, rbyte_rdy & frame_err}, 32'd0);
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk1843); #1;
            rx = 1'b1;
        end
    endtask

    // A glitch flips the line for the one clock that lands on the bit-centre sample.
    task automatic send_bit(input logic v, input logic g);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk1843); #1;
            rx = (g && i == 8) ? ~v : v;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic g);
        @(posedge clk1843); #1;
        rx = 1'b0;
        frame_t0 = cyc;
        for (int i = 1; i < 16; i++) begin
            @(posedge clk1843); #1;
        end
        for (int i = 0; i < 8; i++) send_bit(b[i], g);
        send_bit(stop, 1'b0);
    endtask

    initial begin
        int n0;
        logic [7:0] exp_glitch;

        repeat (3) @(posedge clk1843);
        @(negedge clk1843);
        check("rst_rbyte", {24'd0, rbyte}, 32'h00);
        check("rst_rdy", {31'd0, rbyte_rdy}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk1843); #1;
        rst_n = 1'b1;
        idle(10);

        // single frame, latency
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(20);
        check("a5_count", rdy_cnt, 1);
        check("a5_rbyte", {24'd0, rbyte}, 32'hA5);
        check("a5_ferr", ferr_cnt, 0);
        check("a5_latency", last_rdy - frame_t0, 155);
        check("a5_busy", {31'd0, busy}, 32'd0);

        // back-to-back frames
        n0 = byte_q.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(20);
        check("b2b_count", byte_q.size() - n0, 2);
        if (byte_q.size() >= n0 + 2) begin
            check("b2b_first", {24'd0, byte_q[n0]}, 32'h00);
            check("b2b_second", {24'd0, byte_q[n0+1]}, 32'hFF);
        end
        check("b2b_spacing", last_rdy - prev_rdy, 160);

        // short low pulse rejected as a false start
        n0 = rdy_cnt;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk1843); #1;
            rx = 1'b0;
        end
        idle(2);
        @(negedge clk1843);
        check("glitch_busy_hi", {31'd0, busy}, 32'd1);
        idle(20);
        @(negedge clk1843);
        check("glitch_busy_lo", {31'd0, busy}, 32'd0);
        check("glitch_no_rdy", rdy_cnt - n0, 0);
        check("glitch_no_ferr", ferr_cnt, 0);

        // framing error with line held low, then recovery
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(10);
        check("pre_ferr_rbyte", {24'd0, rbyte}, 32'h3C);
        n0 = rdy_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40) @(posedge clk1843);
        @(negedge clk1843);
        check("ferr_count", ferr_cnt, 1);
        check("ferr_rbyte", {24'd0, rbyte}, 32'h3C);
        check("ferr_no_rdy", rdy_cnt - n0, 0);
        check("ferr_break_busy", {31'd0, busy}, 32'd1);
        idle(10);
        @(negedge clk1843);
        check("break_exit", {31'd0, busy}, 32'd0);
        send_frame(8'h12, 1'b1, 1'b0);
        idle(20);
        check("post_ferr_rbyte", {24'd0, rbyte}, 32'h12);
        check("post_ferr_count", rdy_cnt - n0, 1);
        check("ferr_once", ferr_cnt, 1);

        // reset during data bit 4
        n0 = rdy_cnt;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        idle(5);
        @(negedge clk1843);
        check("mid_busy", {31'd0, busy}, 32'd1);
        @(posedge clk1843); #1;
        rst_n = 1'b0;
        @(posedge clk1843); #1;
        rst_n = 1'b1;
        @(negedge clk1843);
        check("mid_rst_rbyte", {24'd0, rbyte}, 32'h00);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        idle(30);
        check("mid_rst_no_rdy", rdy_cnt - n0, 0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(20);
        check("after_rst_rbyte", {24'd0, rbyte}, 32'h81);
        check("after_rst_count", rdy_cnt - n0, 1);

        // single-clock glitch at every data-bit centre
`ifdef SERIAL_RX_MAJORITY_EN
        exp_glitch = 8'h96;
`else
        exp_glitch = 8'h69;
`endif
        send_frame(8'h96, 1'b1, 1'b1);
        idle(20);
        check("centre_glitch", {24'd0, rbyte}, {24'd0, exp_glitch});
        check("total_ferr", ferr_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
